// File: rtl/mipi_pkg.sv
// rtl/mipi_pkg.sv - shared state encoding and sync constants for the CSI-2 lane aligner
package mipi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HUNT,
      WAIT2,
      LOCKED,
      FAIL
   } align_state_t;

   localparam logic [7:0] SYNC_BYTE        = 8'hB8;
   localparam int         HUNT_TIMEOUT_DEF = 64;
   localparam int         MAX_SKEW_DEF     = 3;

   // Returns {hit, offset}; scanning high to low leaves the lowest matching offset.
   function automatic logic [2:0] find_sync(input logic [11:0] win, input logic [7:0] pattern);
      logic [2:0] r;
      r = 3'b000;
      for (int o = 3; o >= 0; o--) begin
         if (win[o +: 8] == pattern) r = {1'b1, 2'(o)};
      end
      return r;
   endfunction

endpackage

// File: rtl/mipi_lane_sync_detect.sv
// rtl/mipi_lane_sync_detect.sv - per-lane 12-bit window, sync search and deskew delay line
module mipi_lane_sync_detect
   import mipi_pkg::*;
#(
   parameter int MAX_SKEW = MAX_SKEW_DEF
) (
   input  logic       sync_mipi_clk_2,
   input  logic       reset,
   input  logic       clear,
   input  logic [3:0] nib,
   input  logic [1:0] tap_sel,
   input  logic [1:0] phase_sel,
   output logic       match,
   output logic [1:0] phase,
   output logic [7:0] data
);

   logic [11:0] win;
   logic [11:0] dly [1:MAX_SKEW];
   logic [11:0] tap;
   logic [2:0]  hit;

   // Newest nibble enters at the top, so win[0] is the oldest serial bit.
   always_ff @(posedge sync_mipi_clk_2) begin
      if (reset || clear) begin
         win <= '0;
         for (int i = 1; i <= MAX_SKEW; i++) dly[i] <= '0;
      end else begin
         win    <= {nib, win[11:4]};
         dly[1] <= win;
         for (int i = 2; i <= MAX_SKEW; i++) dly[i] <= dly[i-1];
      end
   end

   assign hit   = find_sync(win, SYNC_BYTE);
   assign match = hit[2];
   assign phase = hit[1:0];

   // Tap 0 is the live window; tap k is the window as it stood k cycles ago.
   always_comb begin
      tap = win;
      for (int i = 1; i <= MAX_SKEW; i++) begin
         if (int'(tap_sel) == i) tap = dly[i];
      end
   end

   assign data = tap[phase_sel +: 8];

endmodule

// File: rtl/mipi_lane_align_ctrl.sv
// rtl/mipi_lane_align_ctrl.sv - two-lane CSI-2 sync hunt, skew measurement and aligned byte emission
module mipi_lane_align_ctrl
   import mipi_pkg::*;
#(
   parameter int HUNT_TIMEOUT = HUNT_TIMEOUT_DEF,
   parameter int MAX_SKEW     = MAX_SKEW_DEF
) (
   input  logic       sync_mipi_clk_2,
   input  logic       reset,
   input  logic       stop,
   input  logic [3:0] lane0_nib,
   input  logic [3:0] lane1_nib,
   output logic [7:0] byte0,
   output logic [7:0] byte1,
   output logic       byte_valid,
   output logic       locked,
   output logic       sync_err,
   output logic [1:0] skew,
   output logic       early_lane,
   output logic [1:0] phase0,
   output logic [1:0] phase1
);

   localparam int TW = $clog2(HUNT_TIMEOUT);
   localparam int CW = $clog2(MAX_SKEW + 1);

   align_state_t  state;
   logic [TW-1:0] timer;
   logic [CW-1:0] cnt;
   logic          emit_ph;

   logic       match0, match1, late_match;
   logic [1:0] hit_ph0, hit_ph1;
   logic [1:0] tap0, tap1;
   logic [7:0] data0, data1;

   // The early lane is read from further back in its delay line to line up with the late lane.
   assign tap0       = early_lane ? 2'd0 : skew;
   assign tap1       = early_lane ? skew : 2'd0;
   assign late_match = early_lane ? match0 : match1;

   mipi_lane_sync_detect #(.MAX_SKEW(MAX_SKEW)) u_lane0 (
      .sync_mipi_clk_2 (sync_mipi_clk_2),
      .reset           (reset),
      .clear           (stop),
      .nib             (lane0_nib),
      .tap_sel         (tap0),
      .phase_sel       (phase0),
      .match           (match0),
      .phase           (hit_ph0),
      .data            (data0)
   );

   mipi_lane_sync_detect #(.MAX_SKEW(MAX_SKEW)) u_lane1 (
      .sync_mipi_clk_2 (sync_mipi_clk_2),
      .reset           (reset),
      .clear           (stop),
      .nib             (lane1_nib),
      .tap_sel         (tap1),
      .phase_sel       (phase1),
      .match           (match1),
      .phase           (hit_ph1),
      .data            (data1)
   );

   always_ff @(posedge sync_mipi_clk_2) begin
      if (reset || stop) begin
         state      <= IDLE;
         timer      <= '0;
         cnt        <= '0;
         emit_ph    <= 1'b0;
         byte0      <= '0;
         byte1      <= '0;
         byte_valid <= 1'b0;
         locked     <= 1'b0;
         sync_err   <= 1'b0;
         skew       <= '0;
         early_lane <= 1'b0;
         phase0     <= '0;
         phase1     <= '0;
      end else begin
         byte_valid <= 1'b0;
         sync_err   <= 1'b0;
         case (state)
            IDLE: begin
               state <= HUNT;
               timer <= '0;
            end
            HUNT: begin
               if (match0 && match1) begin
                  state      <= LOCKED;
                  locked     <= 1'b1;
                  emit_ph    <= 1'b0;
                  skew       <= '0;
                  early_lane <= 1'b0;
                  phase0     <= hit_ph0;
                  phase1     <= hit_ph1;
               end else if (match0 || match1) begin
                  state      <= WAIT2;
                  cnt        <= '0;
                  early_lane <= match1;
                  if (match0) phase0 <= hit_ph0;
                  else        phase1 <= hit_ph1;
               end else if (int'(timer) == HUNT_TIMEOUT - 1) begin
                  state    <= FAIL;
                  sync_err <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            WAIT2: begin
               if (late_match && (int'(cnt) + 1 <= MAX_SKEW)) begin
                  state   <= LOCKED;
                  locked  <= 1'b1;
                  emit_ph <= 1'b0;
                  skew    <= 2'(int'(cnt) + 1);
                  if (early_lane) phase0 <= hit_ph0;
                  else            phase1 <= hit_ph1;
               end else if (int'(cnt) + 1 > MAX_SKEW) begin
                  state    <= FAIL;
                  sync_err <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            LOCKED: begin
               // Odd phase lands on the payload byte, skipping the sync byte itself.
               emit_ph <= ~emit_ph;
               if (emit_ph) begin
                  byte_valid <= 1'b1;
                  byte0      <= data0;
                  byte1      <= data1;
               end
            end
            FAIL: begin
               state <= FAIL;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mipi_lane_align_ctrl.sv
// tb/tb_mipi_lane_align_ctrl.sv - scoreboard bench for the two-lane sync/deskew controller
module tb_mipi_lane_align_ctrl;

   logic       clk = 1'b0;
   logic       reset, stop;
   logic [3:0] lane0_nib, lane1_nib;
   logic [7:0] byte0, byte1;
   logic       byte_valid, locked, sync_err, early_lane;
   logic [1:0] skew, phase0, phase1;

   int          n_vec = 0;
   int          n_err = 0;
   bit          bq0[$];
   bit          bq1[$];
   logic [15:0] exp_q[$];
   logic [15:0] sb_exp;

   mipi_lane_align_ctrl dut (
      .sync_mipi_clk_2 (clk),
      .reset           (reset),
      .stop            (stop),
      .lane0_nib       (lane0_nib),
      .lane1_nib       (lane1_nib),
      .byte0           (byte0),
      .byte1           (byte1),
      .byte_valid      (byte_valid),
      .locked          (locked),
      .sync_err        (sync_err),
      .skew            (skew),
      .early_lane      (early_lane),
      .phase0          (phase0),
      .phase1          (phase1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   task automatic push_zeros(input int lane, input int n);
      for (int i = 0; i < n; i++) begin
         if (lane == 0) bq0.push_back(1'b0);
         else           bq1.push_back(1'b0);
      end
   endtask

   // Serial order is LSB first.
   task automatic push_byte(input int lane, input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         if (lane == 0) bq0.push_back(b[i]);
         else           bq1.push_back(b[i]);
      end
   endtask

   task automatic cycle();
      logic [3:0] n0, n1;
      for (int i = 0; i < 4; i++) begin
         if (bq0.size() > 0) n0[i] = bq0.pop_front(); else n0[i] = 1'b0;
         if (bq1.size() > 0) n1[i] = bq1.pop_front(); else n1[i] = 1'b0;
      end
      lane0_nib = n0;
      lane1_nib = n1;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {byte0, byte1, byte_valid, locked, sync_err, skew, early_lane, phase0, phase1}, 32'd0);
   endtask

   task automatic flush();
      bq0.delete();
      bq1.delete();
      exp_q.delete();
   endtask

   task automatic stop_and_check();
      stop = 1'b1;
      cycle();
      chk("sb_drain", exp_q.size(), 0);
      chk_zero("stop_clear");
      flush();
   endtask

   // Sync starts at bit 8+o on both lanes: match seen after edge 4, lock after edge 5.
   task automatic load_aligned(input int o, input logic [7:0] a0, b0, a1, b1);
      push_zeros(0, 8 + o); push_byte(0, 8'hB8); push_byte(0, a0); push_byte(0, b0);
      push_zeros(1, 8 + o); push_byte(1, 8'hB8); push_byte(1, a1); push_byte(1, b1);
      exp_q.push_back({a0, a1});
      exp_q.push_back({b0, b1});
   endtask

   task automatic lock_aligned(input int o, input logic [7:0] a0, b0, a1, b1);
      load_aligned(o, a0, b0, a1, b1);
      stop = 1'b0;
      for (int e = 0; e <= 9; e++) begin
         cycle();
         if (e == 4) chk("pre_lock", locked, 0);
         if (e == 5) begin
            chk("al_locked", locked, 1);
            chk("al_skew", skew, 0);
            chk("al_early", early_lane, 0);
            chk("al_phase0", phase0, o);
            chk("al_phase1", phase1, o);
         end
         if (e >= 5) chk("al_bv_cadence", byte_valid, (e == 7 || e == 9));
      end
   endtask

   // Early lane matches after edge 4, late lane s cycles later.
   task automatic load_skewed(input int early, input int pe, input int pl, input int s,
                              input logic [7:0] pa, input logic [7:0] pb);
      int late;
      late = 1 - early;
      push_zeros(early, 8 + pe);       push_byte(early, 8'hB8);
      push_byte(early, (early == 0) ? pa : pb);
      push_zeros(late, 8 + 4 * s + pl); push_byte(late, 8'hB8);
      push_byte(late, (late == 0) ? pa : pb);
      exp_q.push_back({pa, pb});
   endtask

   task automatic lock_skewed(input int early, input int pe, input int pl, input int s,
                              input logic [7:0] pa, input logic [7:0] pb);
      load_skewed(early, pe, pl, s, pa, pb);
      stop = 1'b0;
      for (int e = 0; e <= 7 + s; e++) begin
         cycle();
         if (e == 5) begin
            chk("wait_early", early_lane, early);
            chk("wait_phase", (early == 1) ? phase1 : phase0, pe);
         end
         if (e == 4 + s) chk("sk_prelock", locked, 0);
         if (e == 5 + s) begin
            chk("sk_locked", locked, 1);
            chk("sk_skew", skew, s);
            chk("sk_early", early_lane, early);
            chk("sk_phase0", phase0, (early == 0) ? pe : pl);
            chk("sk_phase1", phase1, (early == 1) ? pe : pl);
         end
         if (e == 6 + s) chk("sk_bv_gap", byte_valid, 0);
         if (e == 7 + s) chk("sk_bv_first", byte_valid, 1);
      end
   endtask

   // Lane0 matches after edge 4; WAIT2 gives up at edge 4+MAX_SKEW+2.
   task automatic fail_skew(input bit with_late);
      push_zeros(0, 8); push_byte(0, 8'hB8);
      if (with_late) begin
         push_zeros(1, 24); push_byte(1, 8'hB8);
      end
      stop = 1'b0;
      for (int e = 0; e <= 11; e++) begin
         cycle();
         chk("skfail_err", sync_err, (e == 9));
         chk("skfail_lock", locked, 0);
      end
      chk("skfail_bv", byte_valid, 0);
   endtask

   always @(negedge clk) begin
      if (byte_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("extra_byte", byte_valid, 0);
         end else begin
            sb_exp = exp_q.pop_front();
            chk("byte0", byte0, sb_exp[15:8]);
            chk("byte1", byte1, sb_exp[7:0]);
         end
      end
   end

   initial begin
      reset = 1'b1;
      stop  = 1'b0;
      lane0_nib = '0;
      lane1_nib = '0;
      cycle();
      cycle();
      chk_zero("reset_state");
      stop  = 1'b1;
      reset = 1'b0;
      cycle();
      chk_zero("stop_idle");

      lock_aligned(0, 8'h12, 8'h34, 8'h56, 8'h78);
      stop_and_check();

      lock_skewed(0, 1, 3, 2, 8'hA5, 8'h5A);
      stop_and_check();
      lock_skewed(1, 0, 2, 3, 8'hC3, 8'h3C);
      stop_and_check();
      lock_skewed(1, 3, 0, 1, 8'hE7, 8'h7E);
      stop_and_check();

      fail_skew(1'b0);
      stop_and_check();
      fail_skew(1'b1);
      stop_and_check();

      stop = 1'b0;
      for (int e = 0; e <= 66; e++) begin
         cycle();
         chk("timeout_err", sync_err, (e == 64));
      end
      stop_and_check();
      lock_aligned(0, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
      stop_and_check();

      lock_skewed(0, 2, 1, 1, 8'h81, 8'h18);
      stop_and_check();
      lock_aligned(2, 8'h44, 8'h55, 8'h66, 8'h77);
      stop_and_check();

      load_skewed(0, 1, 3, 2, 8'hA5, 8'h5A);
      stop = 1'b0;
      for (int e = 0; e <= 5; e++) cycle();
      chk("rst_wait_phase0", phase0, 1);
      reset = 1'b1;
      cycle();
      chk_zero("rst_in_wait2");
      flush();
      reset = 1'b0;
      for (int e = 0; e < 10; e++) begin
         cycle();
         chk("post_rst_err", sync_err, 0);
         chk("post_rst_bv", byte_valid, 0);
      end
      stop_and_check();

      load_aligned(1, 8'h0F, 8'hF0, 8'h33, 8'hCC);
      stop = 1'b0;
      for (int e = 0; e <= 7; e++) cycle();
      chk("rst_lock_bv", byte_valid, 1);
      reset = 1'b1;
      cycle();
      chk_zero("rst_in_locked");
      flush();
      reset = 1'b0;
      stop  = 1'b1;
      cycle();
      stop = 1'b0;
      for (int e = 0; e < 10; e++) begin
         cycle();
         chk("post_rst2_err", sync_err, 0);
         chk("post_rst2_bv", byte_valid, 0);
         chk("post_rst2_lock", locked, 0);
      end
      stop_and_check();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
